route_dispatch: RTL

//  Parametrised successor dispatcher between ADC front end and PID pipeline. Buffers {src,data} words in an

---
 rtl/route_dispatch.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/route_dispatch.sv
// route_dispatch: buffers {src,data} words in a FIFO and fans each word out to every enabled channel routed to its source.
// Optional macro ROUTE_DISPATCH_OVF_CNT_EN adds ovf_cnt_out, a saturating count of dropped input words.
module route_dispatch #(
  parameter int W_SRC     = 5,
  parameter int N_SRC     = 8,
  parameter int W_CHAN    = 5,
  parameter int N_CHAN    = 8,
  parameter int W_DATA    = 18,
  parameter int W_DEPTH   = 4,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48,
  parameter logic [W_WR_ADDR-1:0] CHAN_EN_ADDR      = 'h0,
  parameter logic [W_WR_ADDR-1:0] CHAN_SRC_SEL_ADDR = 'h1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 dv_in,
  input  logic [W_SRC-1:0]     src_in,
  input  logic [W_DATA-1:0]    data_in,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_CHAN-1:0] wr_chan,
  input  logic [W_WR_DATA-1:0] wr_data,
  input  logic                 rdy_in,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_SRC-1:0]     src_out,
  output logic [W_DATA-1:0]    data_out,
  output logic                 full_out,
  output logic                 ovf_out
`ifdef ROUTE_DISPATCH_OVF_CNT_EN
  ,
  output logic [15:0]          ovf_cnt_out
`endif
);

  localparam int DEPTH = 2 ** W_DEPTH;
  localparam logic [W_SRC:0]   SEL_NULL = {1'b1, {W_SRC{1'b0}}};
  localparam logic [W_SRC:0]   N_SRC_V  = (W_SRC + 1)'(N_SRC);
  localparam logic [W_DEPTH:0] DEPTH_V  = {1'b1, {W_DEPTH{1'b0}}};

  typedef enum logic {IDLE, DISPATCH} state_t;

  state_t                  state;
  logic [N_CHAN-1:0]       chan_en;
  logic [W_SRC:0]          src_sel [N_CHAN];
  logic [W_SRC+W_DATA-1:0] fifo_mem [DEPTH];
  logic [W_DEPTH-1:0]      wr_ptr, rd_ptr;
  logic [W_DEPTH:0]        count;
  logic [N_CHAN-1:0]       pend;

  logic [W_SRC-1:0]  head_src;
  logic [W_DATA-1:0] head_data;
  logic [N_CHAN-1:0] head_route, load_pend, pend_clr;
  logic              busy, full, pop, push, drop;

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^wr_data[W_WR_DATA-1:W_SRC+1];

  function automatic logic [W_CHAN-1:0] lowest_chan(input logic [N_CHAN-1:0] v);
    lowest_chan = '0;
    for (int c = N_CHAN - 1; c >= 0; c--)
      if (v[c]) lowest_chan = W_CHAN'(c);
  endfunction

  assign {head_src, head_data} = fifo_mem[rd_ptr];

  // Routing always uses the live src_sel table at the moment a word is loaded
  always_comb begin
    head_route = '0;
    for (int c = 0; c < N_CHAN; c++)
      head_route[c] = (src_sel[c] == {1'b0, head_src}) && ({1'b0, head_src} < N_SRC_V);
  end

  assign load_pend = head_route & chan_en;
  assign pend_clr  = pend & (pend - N_CHAN'(1));

  // Storage capacity counts the word held for dispatch as well as the FIFO entries
  assign busy     = (state == DISPATCH);
  assign full     = (count + {{W_DEPTH{1'b0}}, busy}) >= DEPTH_V;
  assign pop      = (state == IDLE) && (count != '0);
  assign push     = dv_in && (!full || pop);
  assign drop     = dv_in && !push;
  assign full_out = full;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      chan_en <= '0;
      for (int c = 0; c < N_CHAN; c++) src_sel[c] <= SEL_NULL;
    end else begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (wr_en && (wr_chan == W_WR_CHAN'(c))) begin
          if (wr_addr == CHAN_EN_ADDR)
            chan_en[c] <= wr_data[0];
          else if (wr_addr == CHAN_SRC_SEL_ADDR)
            src_sel[c] <= wr_data[W_SRC:0];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= {src_in, data_in};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_out <= 1'b0;
    end else begin
      ovf_out <= drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dispatch FSM: loads one word per IDLE cycle, then walks its pending channels lowest first
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      pend     <= '0;
      dv_out   <= 1'b0;
      chan_out <= '0;
      src_out  <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && (load_pend != '0)) begin
            pend     <= load_pend;
            src_out  <= head_src;
            data_out <= head_data;
            chan_out <= lowest_chan(load_pend);
            dv_out   <= 1'b1;
            state    <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (rdy_in) begin
            pend <= pend_clr;
            if (pend_clr == '0) begin
              dv_out <= 1'b0;
              state  <= IDLE;
            end else begin
              chan_out <= lowest_chan(pend_clr);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTE_DISPATCH_OVF_CNT_EN
  logic cnt_clr;
  assign cnt_clr = wr_en && (wr_addr == CHAN_EN_ADDR) && (wr_chan == '0) && wr_data[1];

  always_ff @(posedge clk_in) begin
    if (rst_in || cnt_clr)
      ovf_cnt_out <= '0;
    else if (drop && (ovf_cnt_out != 16'hFFFF))
      ovf_cnt_out <= ovf_cnt_out + 16'd1;
  end
`endif

endmodule
